// File: rtl/herald_pkg.sv
// Shared types and helpers for the Herald result drain path.
package herald_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } ser_state_t;

  localparam logic [7:0] HERALD_CSUM_SEED = 8'hA5;

  function automatic int ser_nbytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/herald_byte_mux.sv
// Selects byte idx of a word, LSB first; bytes past WIDTH read as zero.
// Latency: combinational, registered by the parent.
// Backpressure: none, pure select.
module herald_byte_mux #(
  parameter int WIDTH  = 104,
  parameter int NBYTES = 13,
  parameter int IDXW   = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [IDXW-1:0]  idx,
  output logic [7:0]       byte_sel
);

  logic [8*NBYTES-1:0] padded;

  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = data;
    byte_sel = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == IDXW'(i)) byte_sel = padded[8*i +: 8];
    end
  end

endmodule

// File: rtl/herald_result_serializer.sv
// Captures one WIDTH-bit result via EN/RDY put, streams it LSB byte first; HERALD_SER_CHECKSUM_EN appends an XOR checksum byte.
// Latency: byte 0 valid the cycle after the put edge, then one byte per accepted cycle.
// Backpressure: out_byte/out_last hold while out_valid & !out_ready; puts are refused while busy.
module herald_result_serializer
  import herald_pkg::*;
#(
  parameter int WIDTH = 104
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] put_data,
  input  logic             EN_put,
  output logic             RDY_put,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int NBYTES = ser_nbytes(WIDTH);
  localparam int IDXW   = $clog2(NBYTES + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);
`ifdef HERALD_SER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shadow_q;
  logic [IDXW-1:0]  idx_q, idx_d, idx_inc;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             load_shadow;
  logic [WIDTH-1:0] mux_data;
  logic [IDXW-1:0]  mux_idx;
  logic [7:0]       mux_byte;
`ifdef HERALD_SER_CHECKSUM_EN
  logic [7:0]       acc_q, acc_d;
`endif

  assign idx_inc = idx_q + IDXW'(1);

  // In IDLE the mux looks at the incoming word so byte 0 is registered on the put edge.
  herald_byte_mux #(
    .WIDTH (WIDTH),
    .NBYTES(NBYTES),
    .IDXW  (IDXW)
  ) u_byte_mux (
    .data    (mux_data),
    .idx     (mux_idx),
    .byte_sel(mux_byte)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    last_d      = last_q;
    load_shadow = 1'b0;
    mux_data    = shadow_q;
    mux_idx     = idx_inc;
`ifdef HERALD_SER_CHECKSUM_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        mux_data = put_data;
        mux_idx  = '0;
        if (EN_put) begin
          state_d     = SEND;
          idx_d       = '0;
          byte_d      = mux_byte;
          last_d      = (NBYTES == 1) && !CSUM_EN;
          load_shadow = 1'b1;
`ifdef HERALD_SER_CHECKSUM_EN
          acc_d       = 8'h00;
`endif
        end
      end
      SEND: begin
        if (out_ready) begin
`ifdef HERALD_SER_CHECKSUM_EN
          acc_d = acc_q ^ byte_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef HERALD_SER_CHECKSUM_EN
            state_d = CSUM;
            byte_d  = acc_q ^ byte_q ^ HERALD_CSUM_SEED;
            last_d  = 1'b1;
`else
            state_d = IDLE;
            byte_d  = 8'h00;
            last_d  = 1'b0;
`endif
          end else begin
            idx_d  = idx_inc;
            byte_d = mux_byte;
            last_d = (idx_inc == LAST_IDX) && !CSUM_EN;
          end
        end
      end
`ifdef HERALD_SER_CHECKSUM_EN
      CSUM: begin
        if (out_ready) begin
          state_d = IDLE;
          byte_d  = 8'h00;
          last_d  = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        byte_d  = 8'h00;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      byte_q  <= 8'h00;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_q <= '0;
    end else if (load_shadow) begin
      shadow_q <= put_data;
    end
  end

`ifdef HERALD_SER_CHECKSUM_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

  assign RDY_put   = (state_q == IDLE);
  assign busy      = ~RDY_put;
  assign out_valid = (state_q != IDLE);
  assign out_byte  = byte_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_herald_result_serializer.sv
// Scoreboard bench for herald_result_serializer (WIDTH 104 and WIDTH 12 instances).
module tb_herald_result_serializer;

  localparam int W    = 104;
  localparam int NB   = 13;
`ifdef HERALD_SER_CHECKSUM_EN
  localparam int FRAME   = NB + 1;
  localparam int FRAME12 = 3;
`else
  localparam int FRAME   = NB;
  localparam int FRAME12 = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] put_data;
  logic         en_put, rdy_put, out_valid, out_ready, out_last, busy;
  logic [7:0]   out_byte;

  logic [11:0]  put_data12;
  logic         en_put12, rdy_put12, out_valid12, out_last12, busy12;
  logic         out_ready12 = 1'b1;
  logic [7:0]   out_byte12;

  herald_result_serializer #(.WIDTH(W)) u_dut (
    .CLK(clk), .RST_N(rst_n), .put_data(put_data), .EN_put(en_put), .RDY_put(rdy_put),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  herald_result_serializer #(.WIDTH(12)) u_dut12 (
    .CLK(clk), .RST_N(rst_n), .put_data(put_data12), .EN_put(en_put12), .RDY_put(rdy_put12),
    .out_byte(out_byte12), .out_valid(out_valid12), .out_ready(out_ready12), .out_last(out_last12), .busy(busy12)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp12_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   accepted = 0;
  logic hold_pend = 1'b0;
  logic [7:0] hold_byte = 8'h00;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [W-1:0] d);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back('{b: d[8*i +: 8], last: (i == NB - 1) && (FRAME == NB)});
      x = x ^ d[8*i +: 8];
    end
`ifdef HERALD_SER_CHECKSUM_EN
    exp_q.push_back('{b: x ^ 8'hA5, last: 1'b1});
`endif
  endtask

  // Compare every accepted byte; a stalled byte must not change by the next cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", out_byte, 8'hxx);
      end else begin
        e = exp_q.pop_front();
        check("byte", out_byte, e.b);
        check("last", out_last, e.last);
      end
      accepted++;
    end
    if (rst_n && hold_pend && out_valid) check("hold", out_byte, hold_byte);
    hold_pend = rst_n && out_valid && !out_ready;
    hold_byte = out_byte;
  end

  always @(negedge clk) begin : mon12
    exp_t e;
    if (rst_n && out_valid12 && out_ready12) begin
      if (exp12_q.size() == 0) begin
        check("extra_byte12", out_byte12, 8'hxx);
      end else begin
        e = exp12_q.pop_front();
        check("byte12", out_byte12, e.b);
        check("last12", out_last12, e.last);
      end
    end
  end

  task automatic put_word(input logic [W-1:0] d);
    for (int k = 0; k < 300 && !rdy_put; k++) begin
      @(posedge clk); #1;
    end
    check("put_rdy", rdy_put, 1'b1);
    en_put = 1'b1;
    put_data = d;
    push_frame(d);
    @(posedge clk); #1;
    en_put = 1'b0;
    check("lat_valid", out_valid, 1'b1);
  endtask

  task automatic wait_drain(input int mode);
    for (int k = 0; k < 300 && !(exp_q.size() == 0 && rdy_put); k++) begin
      if (mode == 1) out_ready = (k % 4 == 0) || (k % 4 == 3);
      else out_ready = 1'b1;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    check("drain_q", exp_q.size(), 0);
    check("drain_rdy", rdy_put, 1'b1);
  endtask

  initial begin : stim
    logic [W-1:0] words [3];
    int nbusy;
    int acc0;
    en_put = 1'b0; put_data = '0; out_ready = 1'b0;
    en_put12 = 1'b0; put_data12 = '0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      put_data  = {$urandom, $urandom, $urandom, $urandom};
      en_put    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #3;
      check("rst_rdy", rdy_put, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_byte", out_byte, 8'h00);
    end
    @(posedge clk); #1;
    en_put = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_rdy", rdy_put, 1'b1);
    check("rel_rdy12", rdy_put12, 1'b1);

    // Back-to-back full frames with out_ready high.
    words[0] = 104'h0102030405060708090A0B0C0D;
    words[1] = {$urandom, $urandom, $urandom, $urandom};
    words[2] = {W{1'b1}};
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      put_word(words[f]);
      nbusy = 0;
      for (int k = 0; k < 50 && busy; k++) begin
        nbusy++;
        @(posedge clk); #1;
      end
      check("busy_cycles", nbusy, FRAME);
      check("rdy_after", rdy_put, 1'b1);
      check("frame_q", exp_q.size(), 0);
    end

    // Backpressure 1,0,0,1.
    acc0 = accepted;
    out_ready = 1'b0;
    put_word(104'hF0E1D2C3B4A5968778695A4B3C);
    wait_drain(1);
    check("bp_accepts", accepted - acc0, FRAME);

    // Put while busy is ignored.
    out_ready = 1'b1;
    put_word(104'h1122334455667788990011AA55);
    repeat (3) begin @(posedge clk); #1; end
    check("busy_rdy", rdy_put, 1'b0);
    en_put = 1'b1; put_data = {W{1'b1}};
    @(posedge clk); #1;
    en_put = 1'b0; put_data = '0;
    wait_drain(0);
    repeat (3) begin @(posedge clk); #1; end
    check("no_extra", out_valid, 1'b0);

    // Zero-padded top byte, WIDTH 12.
    check("rdy12", rdy_put12, 1'b1);
    put_data12 = 12'hABC; en_put12 = 1'b1;
    exp12_q.push_back('{b: 8'hBC, last: 1'b0});
`ifdef HERALD_SER_CHECKSUM_EN
    exp12_q.push_back('{b: 8'h0A, last: 1'b0});
    exp12_q.push_back('{b: 8'hBC ^ 8'h0A ^ 8'hA5, last: 1'b1});
`else
    exp12_q.push_back('{b: 8'h0A, last: 1'b1});
`endif
    @(posedge clk); #1;
    en_put12 = 1'b0;
    nbusy = 0;
    for (int k = 0; k < 20 && busy12; k++) begin
      nbusy++;
      @(posedge clk); #1;
    end
    check("busy12", nbusy, FRAME12);
    check("q12", exp12_q.size(), 0);

    // Reset mid-frame.
    acc0 = accepted;
    put_word(104'hDEADBEEFCAFEF00D0123456789);
    for (int k = 0; k < 40 && (accepted - acc0) < 5; k++) begin
      @(posedge clk); #1;
    end
    check("mid_accepts", accepted - acc0, 5);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rdy", rdy_put, 1'b1);
    check("mid_valid", out_valid, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_byte", out_byte, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    put_word(104'h0F1E2D3C4B5A69788796A5B4C3);
    wait_drain(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
